// File: rtl/adder_tree_layer_reg.sv
// adder_tree_layer_reg
// One registered stage of a signed binary adder tree. Adjacent input pairs
// are summed into results one bit wider; an odd trailing element passes
// through sign-extended. A valid bit travels alongside so that cascaded
// stages form a one-cycle-per-stage pipeline.

module adder_tree_layer_reg #(
  parameter  int INPUTS_AMOUNT  = 2,
  parameter  int DATAW          = 4,
  localparam int OUTPUTS_AMOUNT = (INPUTS_AMOUNT + 1) / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [DATAW-1:0] inputs  [0:INPUTS_AMOUNT-1],
  output logic             valid_o,
  output logic [DATAW:0]   outputs [0:OUTPUTS_AMOUNT-1]
);

  // Reject degenerate configurations before anything is built.
  if (INPUTS_AMOUNT < 1) begin : g_bad_inputs
    $fatal(1, "adder_tree_layer_reg: INPUTS_AMOUNT must be >= 1");
  end
  if (DATAW < 1) begin : g_bad_dataw
    $fatal(1, "adder_tree_layer_reg: DATAW must be >= 1");
  end

  // Widen a two's-complement operand by one bit so the pair sum is exact.
  function automatic logic [DATAW:0] sext(input logic [DATAW-1:0] v);
    return {v[DATAW-1], v};
  endfunction

  logic [DATAW:0] sum_s     [0:OUTPUTS_AMOUNT-1];
  logic [DATAW:0] outputs_r [0:OUTPUTS_AMOUNT-1];
  logic           valid_r;

  // Pairwise sums; the final slot is a plain pass-through when the count is odd.
  for (genvar k = 0; k < OUTPUTS_AMOUNT; k++) begin : g_pair
    if (2 * k + 1 < INPUTS_AMOUNT) begin : g_sum
      assign sum_s[k] = sext(inputs[2*k]) + sext(inputs[2*k+1]);
    end else begin : g_pass
      assign sum_s[k] = sext(inputs[2*k]);
    end
  end

  // Result registers: cleared by reset, loaded only on valid cycles, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      for (int k = 0; k < OUTPUTS_AMOUNT; k++) begin
        outputs_r[k] <= {(DATAW + 1){1'b0}};
      end
    end else begin
      valid_r <= valid_i;
      if (valid_i) begin
        outputs_r <= sum_s;
      end
    end
  end

  assign valid_o = valid_r;
  assign outputs = outputs_r;

endmodule

// File: tb/tb_adder_tree_layer_reg.sv
// Self-checking bench for adder_tree_layer_reg: directed vectors on a 4-input
// and a 3-input stage, plus a random 8->4->2->1 cascade checked against a
// software sum through a scoreboard queue.

module tb_adder_tree_layer_reg;

  logic clk;
  logic rst_n;

  // Stage A: 4 inputs, 5 bits
  logic       va_i;
  logic [4:0] a_in  [0:3];
  logic       va_o;
  logic [5:0] a_out [0:1];

  // Stage B: 3 inputs, 4 bits
  logic       vb_i;
  logic [3:0] b_in  [0:2];
  logic       vb_o;
  logic [4:0] b_out [0:1];

  // Cascade 8 -> 4 -> 2 -> 1
  logic       vc_i;
  logic [4:0] c_in   [0:7];
  logic       v1, v2, v3;
  logic [5:0] c1_out [0:3];
  logic [6:0] c2_out [0:1];
  logic [7:0] c3_out [0:0];

  int total = 0;
  int bad   = 0;

  logic [12:0] qa[$];
  logic [10:0] qb[$];
  logic [7:0]  qc[$];

  adder_tree_layer_reg #(.INPUTS_AMOUNT(4), .DATAW(5)) u_a (
    .clk(clk), .rst_n(rst_n), .valid_i(va_i), .inputs(a_in), .valid_o(va_o), .outputs(a_out));

  adder_tree_layer_reg #(.INPUTS_AMOUNT(3), .DATAW(4)) u_b (
    .clk(clk), .rst_n(rst_n), .valid_i(vb_i), .inputs(b_in), .valid_o(vb_o), .outputs(b_out));

  adder_tree_layer_reg #(.INPUTS_AMOUNT(8), .DATAW(5)) u_c1 (
    .clk(clk), .rst_n(rst_n), .valid_i(vc_i), .inputs(c_in), .valid_o(v1), .outputs(c1_out));

  adder_tree_layer_reg #(.INPUTS_AMOUNT(4), .DATAW(6)) u_c2 (
    .clk(clk), .rst_n(rst_n), .valid_i(v1), .inputs(c1_out), .valid_o(v2), .outputs(c2_out));

  adder_tree_layer_reg #(.INPUTS_AMOUNT(2), .DATAW(7)) u_c3 (
    .clk(clk), .rst_n(rst_n), .valid_i(v2), .inputs(c2_out), .valid_o(v3), .outputs(c3_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive stage A for one cycle, queue the expected result, then compare.
  task automatic step_a(input logic v, input int x0, input int x1, input int x2, input int x3,
                        input logic ev, input int e0, input int e1, input string tag);
    logic [5:0] p0;
    logic [5:0] p1;
    p0 = e0[5:0];
    p1 = e1[5:0];
    qa.push_back({ev, p1, p0});
    va_i = v;
    a_in[0] = x0[4:0]; a_in[1] = x1[4:0]; a_in[2] = x2[4:0]; a_in[3] = x3[4:0];
    @(posedge clk); #1;
    chk(tag, 32'({va_o, a_out[1], a_out[0]}), 32'(qa.pop_front()));
  endtask

  // Drive stage B for one cycle, queue the expected result, then compare.
  task automatic step_b(input logic v, input int x0, input int x1, input int x2,
                        input logic ev, input int e0, input int e1, input string tag);
    logic [4:0] p0;
    logic [4:0] p1;
    p0 = e0[4:0];
    p1 = e1[4:0];
    qb.push_back({ev, p1, p0});
    vb_i = v;
    b_in[0] = x0[3:0]; b_in[1] = x1[3:0]; b_in[2] = x2[3:0];
    @(posedge clk); #1;
    chk(tag, 32'({vb_o, b_out[1], b_out[0]}), 32'(qb.pop_front()));
  endtask

  initial begin
    logic [2:0] vh;
    int         sent;
    int         cyc;
    int         s;
    int         r;

    // Reset held with valid inputs and nonzero data
    rst_n = 1'b0;
    va_i = 1'b1; vb_i = 1'b1; vc_i = 1'b1;
    for (int i = 0; i < 4; i++) a_in[i] = 5'd5;
    for (int i = 0; i < 3; i++) b_in[i] = 4'd3;
    for (int i = 0; i < 8; i++) c_in[i] = 5'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", 32'({va_o, a_out[1], a_out[0]}), 32'd0);
    chk("rst_b", 32'({vb_o, b_out[1], b_out[0]}), 32'd0);
    chk("rst_c", 32'({v1, v2, v3, c3_out[0]}), 32'd0);

    rst_n = 1'b1;
    vb_i = 1'b0; vc_i = 1'b0;

    // Directed signed pairs and width extremes
    step_a(1'b1, 3, -2, -16, -16, 1'b1, 1, -32, "a_signed");
    step_a(1'b1, 15, 15, -16, 15, 1'b1, 30, -1, "a_extreme");

    // Odd count: last element passes through sign-extended
    step_b(1'b1, 7, 1, -8, 1'b1, 8, -8, "b_odd");
    step_b(1'b0, 1, 1, 1, 1'b0, 8, -8, "b_hold");

    // Streaming with an idle cycle that must hold the second result
    step_a(1'b0, 9, 9, 9, 9, 1'b0, 30, -1, "a_idle0");
    step_a(1'b1, 1, 2, 3, 4, 1'b1, 3, 7, "a_str1");
    step_a(1'b1, -5, -6, 7, 7, 1'b1, -11, 14, "a_str2");
    step_a(1'b0, 5, 5, 5, 5, 1'b0, -11, 14, "a_str_idle");
    step_a(1'b1, -16, -1, 0, -16, 1'b1, -17, -16, "a_str3");

    // Reset mid-stream overrides a valid input and clears held data
    rst_n = 1'b0;
    vb_i = 1'b1;
    vc_i = 1'b1;
    step_a(1'b1, 1, 1, 1, 1, 1'b0, 0, 0, "a_midrst");
    chk("b_midrst", 32'({vb_o, b_out[1], b_out[0]}), 32'd0);
    rst_n = 1'b1;
    vb_i = 1'b0;
    vc_i = 1'b0;
    va_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("c_idle", 32'({v1, v2, v3}), 32'd0);

    // Random cascade through the scoreboard
    vh = 3'b000;
    sent = 0;
    cyc = 0;
    while (sent < 1000 || qc.size() > 0) begin
      if (cyc > 3000) begin
        chk("c_timeout", 32'(qc.size()), 32'd0);
        break;
      end
      if (sent < 1000 && $urandom_range(7, 0) != 0) begin
        vc_i = 1'b1;
        s = 0;
        for (int i = 0; i < 8; i++) begin
          r = int'($urandom_range(30, 0)) - 15;
          c_in[i] = r[4:0];
          s += r;
        end
        qc.push_back(s[7:0]);
        sent++;
      end else begin
        vc_i = 1'b0;
        for (int i = 0; i < 8; i++) c_in[i] = 5'($urandom_range(31, 0));
      end
      vh = {vh[1:0], vc_i};
      @(posedge clk); #1;
      cyc++;
      chk("c_valid", 32'(v3), 32'(vh[2]));
      if (v3) begin
        if (qc.size() == 0) chk("c_extra", 32'd1, 32'd0);
        else chk("c_sum", 32'(c3_out[0]), 32'(qc.pop_front()));
      end
    end
    vc_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
